// File: rtl/audio_pkg.sv
// audio_pkg
// Shared constants and types for the I2S serializer block.
//   AUDIO_SAMPLE_W  : default sample width in bits
//   AUDIO_CLK_DIV   : default system clocks per bclk half-period
//   AUDIO_SLOT_BITS : default bclk periods per channel slot
//   slot_state_t    : slot state machine encoding (IDLE / LEFT / RIGHT)
package audio_pkg;

  localparam int AUDIO_SAMPLE_W  = 16;
  localparam int AUDIO_CLK_DIV   = 16;
  localparam int AUDIO_SLOT_BITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } slot_state_t;

endpackage

// File: rtl/audio_clk_div.sv
// audio_clk_div
// Bit-clock divider. While run is high, bclk toggles every CLK_DIV system
// clocks. While run is low, the divider is parked with bclk = 0 and its count
// at 0, so the first rising bclk edge comes CLK_DIV clocks after run rises.
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous active-low reset
//   run       in   divider enable
//   bclk      out  bit clock
//   bclk_fall out  high in the cycle whose clock edge takes bclk from 1 to 0
module audio_clk_div
  import audio_pkg::*;
#(
  parameter int CLK_DIV = AUDIO_CLK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic bclk,
  output logic bclk_fall
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             bclk_reg;
  logic             wrap;

  assign wrap      = (div_cnt_reg == DIV_LAST);
  // Combinational strobe so the slot logic updates on the same edge that
  // drives bclk low.
  assign bclk_fall = run && wrap && bclk_reg;
  assign bclk      = bclk_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else if (!run) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else if (wrap) begin
      div_cnt_reg <= '0;
      bclk_reg    <= ~bclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/audio_i2s_serializer.sv
// audio_i2s_serializer
// Serializes a 16-bit mono sample in I2S format, repeating it in the left and
// right slots. Generates bclk and lrck for the codec and hands lrck plus a
// one-cycle-delayed copy back to the fetch controller, which advances a sample
// on each lrck fall. The sample is latched on the second bclk fall of the left
// slot, 2*CLK_DIV clocks after lrck falls.
// Optional feature (macro AUDIO_VOLUME_EN): adds a 3-bit volume input; the
// latched word becomes the sample arithmetically shifted right by volume.
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous active-low reset
//   enable     in   run; when low, the current frame finishes, then idle
//   mute       in   send zeros (sampled at the latch edge only)
//   sample_in  in   two's-complement sample
//   volume     in   attenuation shift (AUDIO_VOLUME_EN builds only)
//   bclk       out  codec bit clock
//   lrck       out  frame clock, 0 = left slot, 1 = right slot
//   lrck_last  out  lrck delayed by one clock
//   dacdat     out  serial data, MSB first, one bclk after each lrck edge
module audio_i2s_serializer
  import audio_pkg::*;
#(
  parameter int CLK_DIV   = AUDIO_CLK_DIV,
  parameter int SLOT_BITS = AUDIO_SLOT_BITS,
  parameter int SAMPLE_W  = AUDIO_SAMPLE_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                mute,
  input  logic [SAMPLE_W-1:0] sample_in,
`ifdef AUDIO_VOLUME_EN
  input  logic [2:0]          volume,
`endif
  output logic                bclk,
  output logic                lrck,
  output logic                lrck_last,
  output logic                dacdat
);

  localparam int BIT_W = $clog2(SLOT_BITS);
  localparam int IDX_W = $clog2(SAMPLE_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_BITS - 1);

  slot_state_t         state_reg, state_next;
  logic                lrck_reg, lrck_next;
  logic                lrck_last_reg;
  logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [SAMPLE_W-1:0] word_reg, word_next;
  logic                dacdat_reg, dacdat_next;
  logic [SAMPLE_W-1:0] shifted;
  logic [SAMPLE_W-1:0] latch_val;
  logic                run;
  logic                bclk_fall;

  // Data bit for slot bit k. Bit k = 0 is the I2S one-bit delay slot and
  // carries the previous slot's LSB when the slot is exactly sample-wide;
  // bits past the sample are padded with zeros.
  function automatic logic data_bit(input logic [SAMPLE_W-1:0] w,
                                    input logic [BIT_W-1:0] k);
    int   pos;
    logic b;
    b   = 1'b0;
    pos = SAMPLE_W - int'(k);
    if (k == '0) begin
      b = (SLOT_BITS == SAMPLE_W) ? w[0] : 1'b0;
    end else if (pos >= 0) begin
      b = w[pos[IDX_W-1:0]];
    end
    return b;
  endfunction

`ifdef AUDIO_VOLUME_EN
  assign shifted = SAMPLE_W'($signed(sample_in) >>> volume);
`else
  assign shifted = sample_in;
`endif

  assign latch_val = mute ? '0 : shifted;
  assign run       = (state_reg != IDLE);

  audio_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .bclk      (bclk),
    .bclk_fall (bclk_fall)
  );

  always_comb begin
    state_next   = state_reg;
    lrck_next    = lrck_reg;
    bit_cnt_next = bit_cnt_reg;
    word_next    = word_reg;
    dacdat_next  = dacdat_reg;
    case (state_reg)
      IDLE: begin
        lrck_next    = 1'b1;
        dacdat_next  = 1'b0;
        bit_cnt_next = '0;
        if (enable) begin
          // The entry edge itself is slot bit 0 of the left slot.
          state_next  = LEFT;
          lrck_next   = 1'b0;
          dacdat_next = data_bit(word_reg, '0);
        end
      end
      LEFT, RIGHT: begin
        if (bclk_fall) begin
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
            if (state_reg == LEFT) begin
              state_next  = RIGHT;
              lrck_next   = 1'b1;
              dacdat_next = data_bit(word_reg, '0);
            end else if (enable) begin
              state_next  = LEFT;
              lrck_next   = 1'b0;
              dacdat_next = data_bit(word_reg, '0);
            end else begin
              // Frame done with enable low: park with lrck high.
              state_next  = IDLE;
              lrck_next   = 1'b1;
              dacdat_next = 1'b0;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (state_reg == LEFT && bit_cnt_reg == '0) begin
              // Latch edge: the MSB goes out on the same edge, taken from
              // the fresh value rather than the stale word.
              word_next   = latch_val;
              dacdat_next = data_bit(latch_val, bit_cnt_next);
            end else begin
              dacdat_next = data_bit(word_reg, bit_cnt_next);
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      lrck_reg      <= 1'b1;
      lrck_last_reg <= 1'b1;
      bit_cnt_reg   <= '0;
      word_reg      <= '0;
      dacdat_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lrck_reg      <= lrck_next;
      lrck_last_reg <= lrck_reg;
      bit_cnt_reg   <= bit_cnt_next;
      word_reg      <= word_next;
      dacdat_reg    <= dacdat_next;
    end
  end

  assign lrck      = lrck_reg;
  assign lrck_last = lrck_last_reg;
  assign dacdat    = dacdat_reg;

endmodule

// File: tb/tb_audio_i2s_serializer.sv
// tb_audio_i2s_serializer
// Directed bench for audio_i2s_serializer with CLK_DIV = 2, SLOT_BITS = 16.
// One bclk period is 4 clocks, so slot bit j of a frame appears on the clock
// edge 4*j cycles after the lrck fall; a full frame is 128 clocks.
module tb_audio_i2s_serializer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        mute;
  logic [15:0] sample_in;
  logic        bclk;
  logic        lrck;
  logic        lrck_last;
  logic        dacdat;

  int n_checks;
  int n_errors;
  int cyc;
  int lrck_last_err;
  logic lrck_q;
  logic mon_en;

  audio_i2s_serializer #(
    .CLK_DIV   (2),
    .SLOT_BITS (16),
    .SAMPLE_W  (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .mute      (mute),
    .sample_in (sample_in),
`ifdef AUDIO_VOLUME_EN
    .volume    (3'd0),
`endif
    .bclk      (bclk),
    .lrck      (lrck),
    .lrck_last (lrck_last),
    .dacdat    (dacdat)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // lrck_last must equal the lrck seen one clock earlier.
  initial begin
    lrck_last_err = 0;
    lrck_q        = 1'b1;
  end
  always @(negedge clock) begin
    if (mon_en) begin
      if (lrck_last !== lrck_q) lrck_last_err <= lrck_last_err + 1;
      lrck_q <= lrck;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the negedge right after an lrck fall.
  task automatic wait_lrck_fall(output logic found);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (lrck === 1'b0 && lrck_last === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  // Captures the 32 data bits following an lrck fall (falls 1..32). A hook
  // drives new inputs one clock into bit interval hook_at.
  task automatic run_frame(input string tag, input int hook_at,
                           input logic [15:0] h_sample, input logic h_mute,
                           input logic h_enable, input logic [31:0] exp_bits,
                           input logic exp_lrck_end, output int t0,
                           output logic k0_val);
    logic [31:0] bits;
    logic        found;
    wait_lrck_fall(found);
    check({tag, "_start"}, 32'(found), 32'd1);
    t0     = cyc;
    k0_val = dacdat;
    bits   = '0;
    for (int j = 1; j <= 32; j++) begin
      for (int c = 1; c <= 4; c++) begin
        @(posedge clock);
        if (j == hook_at && c == 1) begin
          #1;
          sample_in = h_sample;
          mute      = h_mute;
          enable    = h_enable;
        end
      end
      @(negedge clock);
      bits[32-j] = dacdat;
      if (j == 1)  check({tag, "_msb"}, 32'(dacdat), 32'(exp_bits[31]));
      if (j == 16) check({tag, "_lrck_right"}, 32'(lrck), 32'd1);
    end
    check({tag, "_bits"}, bits, exp_bits);
    check({tag, "_lrck_end"}, 32'(lrck), 32'(exp_lrck_end));
    $display("frame %s: t0=%0d bits=%h expected %h", tag, t0, bits, exp_bits);
  endtask

  initial begin
    int   t1, t2, t_dummy;
    int   bad_bclk, bad_lrck, bad_last, bad_dat;
    logic k0;
    logic found;

    n_checks  = 0;
    n_errors  = 0;
    mon_en    = 1'b1;
    reset     = 1'b0;
    enable    = 1'b0;
    mute      = 1'b0;
    sample_in = 16'h0000;
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Idle after reset with enable low.
    bad_bclk = 0; bad_lrck = 0; bad_last = 0; bad_dat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bclk !== 1'b0)      bad_bclk++;
      if (lrck !== 1'b1)      bad_lrck++;
      if (lrck_last !== 1'b1) bad_last++;
      if (dacdat !== 1'b0)    bad_dat++;
    end
    check("idle_bclk", 32'(bad_bclk), 32'd0);
    check("idle_lrck", 32'(bad_lrck), 32'd0);
    check("idle_lrck_last", 32'(bad_last), 32'd0);
    check("idle_dacdat", 32'(bad_dat), 32'd0);
    $display("idle: 100 cycles observed");

    // Frame 1: A5C3 from idle; stale word is 0 so left bit 0 is 0.
    sample_in = 16'hA5C3;
    enable    = 1'b1;
    run_frame("f1_a5c3", 20, 16'h1234, 1'b0, 1'b1, {16'hA5C3, 16'hA5C3}, 1'b0, t1, k0);
    check("f1_left_k0", 32'(k0), 32'd0);

    // Frame 2: sample_in changes 1234 -> 8001 one clock after the lrck fall.
    run_frame("f2_8001", 1, 16'h8001, 1'b0, 1'b1, {16'h8001, 16'h8001}, 1'b0, t2, k0);
    check("frame_period", 32'(t2 - t1), 32'd128);
    check("f2_left_k0", 32'(k0), 32'd1);

    // Frame 3: muted before the latch edge.
    run_frame("f3_mute", 1, 16'h8001, 1'b1, 1'b1, 32'h0000_0000, 1'b0, t_dummy, k0);

    // Frame 4: mute released, data resumes.
    run_frame("f4_3c5b", 1, 16'h3C5B, 1'b0, 1'b1, {16'h3C5B, 16'h3C5B}, 1'b0, t_dummy, k0);

    // Frame 5: enable dropped mid-left; right slot still completes, then the
    // would-be next-left bit 0 is 0 because the block returns to idle.
    run_frame("f5_stop", 5, 16'h3C5B, 1'b0, 1'b0, {16'h3C5B, 16'h3C5A}, 1'b1, t_dummy, k0);

    bad_bclk = 0; bad_lrck = 0; bad_dat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bclk !== 1'b0) bad_bclk++;
      if (lrck !== 1'b1) bad_lrck++;
      if (dacdat !== 1'b0) bad_dat++;
    end
    check("stop_idle_bclk", 32'(bad_bclk), 32'd0);
    check("stop_idle_lrck", 32'(bad_lrck), 32'd0);
    check("stop_idle_dacdat", 32'(bad_dat), 32'd0);
    $display("stop: idle after enable drop");

    // Frame 6: restart; left bit 0 carries the LSB of the held word 3C5B.
    sample_in = 16'hF00F;
    enable    = 1'b1;
    wait_lrck_fall(found);
    check("f6_start", 32'(found), 32'd1);
    check("f6_left_k0", 32'(dacdat), 32'd1);
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("pre_reset_bclk", 32'(bclk), 32'd1);
    check("pre_reset_dacdat", 32'(dacdat), 32'd1);
    check("lrck_last_delay", 32'(lrck_last_err), 32'd0);

    // Mid-slot reset: outputs return to reset values without a clock edge.
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("rst_bclk", 32'(bclk), 32'd0);
    check("rst_lrck", 32'(lrck), 32'd1);
    check("rst_lrck_last", 32'(lrck_last), 32'd1);
    check("rst_dacdat", 32'(dacdat), 32'd0);
    $display("reset: asserted mid-slot");
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/audio_i2s_serializer.md
Name: audio_i2s_serializer

Overview:
- Downstream stage of the ROM sample fetch controller.
- Generates the codec bit clock (bclk) and frame clock (lrck), and returns lrck plus its one-cycle-delayed copy lrck_last to the fetch controller, which advances a sample on each lrck falling edge.
- Latches the 16-bit mono sample, sends it MSB-first in I2S format on dacdat, and repeats it in both left and right slots.

Parameters:
- CLK_DIV, 16, system clocks per bclk half-period; must be ≥ 2.
- SLOT_BITS, 16, bclk periods per channel slot; must be ≥ SAMPLE_W.
- SAMPLE_W, 16, sample width in bits.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run the serializer; low means finish the current frame, then idle.
- mute  in  1  send zeros; connected to the fetch controller's finishMusic.
- sample_in  in  SAMPLE_W  two's-complement sample from the fetch controller's dataOut.
- bclk  out  1  codec bit clock.
- lrck  out  1  frame clock: 0 = left slot, 1 = right slot.
- lrck_last  out  1  lrck delayed by one clock cycle.
- dacdat  out  1  serial data to the codec.

Behaviour:
- Reset (asynchronous, while reset = 0):
  - bclk = 0, lrck = 1, lrck_last = 1, dacdat = 0.
  - div_cnt = 0, bit_cnt = 0, word = 0, state = IDLE.
- Registers:
  - div_cnt counts 0..CLK_DIV-1.
  - bit_cnt counts 0..SLOT_BITS-1.
  - word is SAMPLE_W bits and holds the latched sample.
  - lrck_last <= lrck every cycle, including in IDLE.
- Divider:
  - When div_cnt == CLK_DIV-1, div_cnt wraps to 0 and bclk toggles.
  - A 1→0 toggle is a "bclk fall"; all output updates below happen only at a bclk fall.
- State machine IDLE / LEFT / RIGHT:
  - IDLE: bclk held at 0, div_cnt held at 0, lrck = 1, dacdat = 0. When enable = 1, the next cycle enters LEFT.
  - Entering LEFT: lrck <= 0 and bit_cnt <= 0. This first edge counts as slot bit k = 0, and the divider starts running.
  - At each bclk fall, bit_cnt increments. When bit_cnt == SLOT_BITS-1, the next fall toggles lrck, resets bit_cnt to 0 and switches slot (LEFT→RIGHT, RIGHT→LEFT).
  - At the end of RIGHT: if enable = 0, go to IDLE (lrck stays 1, bclk forced to 0). Otherwise go to LEFT.
- Data per slot, at bclk fall number k:
  - k = 0: dacdat = word[0] if SLOT_BITS == SAMPLE_W, else 0. This is the I2S one-bit delay.
  - k = 1 in LEFT: word <= (mute ? 0 : sample_in), and dacdat = (mute ? 0 : sample_in[SAMPLE_W-1]) in the same edge.
  - 1 ≤ k ≤ SAMPLE_W: dacdat = word[SAMPLE_W-k]. In LEFT at k = 1 this uses the freshly latched value.
  - k > SAMPLE_W: dacdat = 0.
  - RIGHT repeats the same word; the sample is not re-latched.
- Timing towards the fetch controller:
  - The sample latch happens 2·CLK_DIV cycles after the lrck fall, which is ≥ 4 cycles.
  - The fetch controller registers its new dataOut 1 cycle after seeing lrck_last = 1, lrck = 0, so the latched word is the sample fetched for this frame.
  - If the fetch misses that window, the previous dataOut is sent. No error is flagged.
- Simultaneous events:
  - mute is sampled only at the latch edge; a mute change mid-frame takes effect next frame.
  - enable falling mid-frame completes the frame, including RIGHT.
  - Reset asserted mid-frame aborts immediately to the reset values.
- Frame rate: fs = f_clock / (4·CLK_DIV·SLOT_BITS). Defaults at 50 MHz give 48.828 kHz.

Optional Feature:
- Macro: AUDIO_VOLUME_EN.
- Defined: adds a port volume (in, 3 bits). The latched word becomes the arithmetic right shift of the sample by volume (sign-extended). volume is sampled at the latch edge.
- Undefined: no volume port; the word is the sample unmodified.

Decomposition:
- Package audio_pkg:
  - SAMPLE_W.
  - State encoding IDLE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2.
  - Default CLK_DIV and SLOT_BITS.
- Sub-module audio_clk_div: the divider. It produces bclk, a one-cycle bclk_fall strobe and a run input. The top level holds the slot FSM and the shift logic.

Test Plan (CLK_DIV = 2, SLOT_BITS = 16 unless noted):
- Reset released with enable = 0 → bclk = 0, lrck = 1, lrck_last = 1, dacdat = 0, held for 100 cycles.
- enable = 1, sample_in = 16'hA5C3 → lrck falls. dacdat at left falls k = 1..16 is 1010010111000011, then the same 16 bits in the right slot. Right-slot k = 0 carries word[0] = 1.
- lrck period → exactly 128 clock cycles (2·CLK_DIV·SLOT_BITS·2); lrck_last equals lrck delayed by exactly 1 cycle.
- sample_in changes from 16'h1234 to 16'h8001 one cycle after the lrck fall → the latch captures 16'h8001. The MSB is sent 4 cycles after the lrck fall.
- mute = 1 before the latch edge → all 32 slot bits are 0. mute = 0 for the next frame → data resumes.
- enable dropped mid-left-slot → the frame completes through RIGHT and returns to IDLE with lrck = 1. Reset pulsed low mid-slot → outputs take reset values within the same cycle.
